// File: rtl/dsa_scan_ctrl.sv
// Raster-order job sequencer for the bilinear scaler; optional DSA_SCAN_PERF_EN adds perf/stall counters.
// Latency: start edge sampled in cycle N gives first px_valid in cycle N+3, then up to one job per cycle.
// Backpressure: payload held stable while px_ready is low; issue pauses at MAX_OUTSTANDING unacked jobs.
module dsa_scan_ctrl #(
    parameter int AW              = 12,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic          clk_sys,
    input  logic          rst_sys,
    input  logic          start_pulse,
    input  logic [15:0]   cfg_in_w,
    input  logic [15:0]   cfg_in_h,
    input  logic [15:0]   cfg_scale_q88,
    input  logic [15:0]   cfg_inv_scale_q88,
    output logic          px_valid,
    input  logic          px_ready,
    output logic [15:0]   px_x0,
    output logic [15:0]   px_y0,
    output logic [7:0]    px_fx,
    output logic [7:0]    px_fy,
    output logic [AW-1:0] px_out_addr,
    input  logic          px_ack,
    output logic          busy,
    output logic          status_done,
    output logic          err_size,
    output logic [15:0]   out_w,
    output logic [15:0]   out_h
`ifdef DSA_SCAN_PERF_EN
    ,
    output logic [31:0]   perf_cycles,
    output logic [31:0]   stall_cycles
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CHECK,
        S_ISSUE,
        S_DRAIN
    } state_e;

    localparam logic [3:0]  MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [32:0] MAX_PIX = 33'd1 << AW;

    state_e        state_q, state_d;
    logic          start_prev_q, start_prev_d;
    logic [15:0]   in_w_q, in_w_d;
    logic [15:0]   in_h_q, in_h_d;
    logic [15:0]   scale_q, scale_d;
    logic [15:0]   inv_q, inv_d;
    logic [15:0]   out_w_q, out_w_d;
    logic [15:0]   out_h_q, out_h_d;
    logic [15:0]   ox_q, ox_d;
    logic [15:0]   oy_q, oy_d;
    logic [23:0]   sx_q, sx_d;
    logic [23:0]   sy_q, sy_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [3:0]    outst_q, outst_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          start_edge;
    logic          accept;
    logic          fire;
    logic          ack_eff;
    logic [31:0]   prod_w;
    logic [31:0]   prod_h;
    logic [31:0]   area;
    logic          size_bad;
    logic [15:0]   in_w_m1;
    logic [15:0]   in_h_m1;
    logic          clamp_x;
    logic          clamp_y;

    function automatic logic [15:0] clamp_dim(input logic [31:0] prod);
        if (prod < 32'h0000_0100) begin
            clamp_dim = 16'd1;
        end else if (prod >= 32'h0100_0000) begin
            clamp_dim = 16'hFFFF;
        end else begin
            clamp_dim = prod[23:8];
        end
    endfunction

    assign start_edge = start_pulse && !start_prev_q;
    assign accept     = (state_q == S_IDLE) && start_edge;
    assign prod_w     = {16'd0, in_w_q} * {16'd0, scale_q};
    assign prod_h     = {16'd0, in_h_q} * {16'd0, scale_q};
    assign area       = {16'd0, out_w_q} * {16'd0, out_h_q};
    assign size_bad   = (in_w_q == 16'd0) || (in_h_q == 16'd0) || ({1'b0, area} > MAX_PIX);

    // Source coordinate is pinned to the last column/row so the 2x2 neighbourhood stays inside the image.
    assign in_w_m1 = in_w_q - 16'd1;
    assign in_h_m1 = in_h_q - 16'd1;
    assign clamp_x = sx_q[23:8] >= in_w_m1;
    assign clamp_y = sy_q[23:8] >= in_h_m1;

    assign px_valid    = (state_q == S_ISSUE) && (outst_q < MAX_OUT);
    assign px_x0       = clamp_x ? in_w_m1 : sx_q[23:8];
    assign px_fx       = clamp_x ? 8'd0 : sx_q[7:0];
    assign px_y0       = clamp_y ? in_h_m1 : sy_q[23:8];
    assign px_fy       = clamp_y ? 8'd0 : sy_q[7:0];
    assign px_out_addr = addr_q;
    assign fire        = px_valid && px_ready;
    assign ack_eff     = px_ack && (outst_q != 4'd0);

    assign busy        = (state_q != S_IDLE) && !((state_q == S_DRAIN) && (outst_q == 4'd0));
    assign status_done = done_q;
    assign err_size    = err_q;
    assign out_w       = out_w_q;
    assign out_h       = out_h_q;

    always_comb begin
        state_d      = state_q;
        start_prev_d = start_pulse;
        in_w_d       = in_w_q;
        in_h_d       = in_h_q;
        scale_d      = scale_q;
        inv_d        = inv_q;
        out_w_d      = out_w_q;
        out_h_d      = out_h_q;
        ox_d         = ox_q;
        oy_d         = oy_q;
        sx_d         = sx_q;
        sy_d         = sy_q;
        addr_d       = addr_q;
        done_d       = done_q;
        err_d        = err_q;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    in_w_d  = cfg_in_w;
                    in_h_d  = cfg_in_h;
                    scale_d = cfg_scale_q88;
                    inv_d   = cfg_inv_scale_q88;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                out_w_d = clamp_dim(prod_w);
                out_h_d = clamp_dim(prod_h);
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (size_bad) begin
                    err_d   = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    ox_d    = 16'd0;
                    oy_d    = 16'd0;
                    sx_d    = 24'd0;
                    sy_d    = 24'd0;
                    addr_d  = '0;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (fire) begin
                    // Raster order makes oy*out_w+ox a plain running count.
                    addr_d = addr_q + AW'(1);
                    if (ox_q == out_w_q - 16'd1) begin
                        ox_d = 16'd0;
                        sx_d = 24'd0;
                        oy_d = oy_q + 16'd1;
                        sy_d = sy_q + {8'd0, inv_q};
                        if (oy_q == out_h_q - 16'd1) begin
                            state_d = S_DRAIN;
                        end
                    end else begin
                        ox_d = ox_q + 16'd1;
                        sx_d = sx_q + {8'd0, inv_q};
                    end
                end
            end
            S_DRAIN: begin
                if (outst_q == 4'd0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        outst_d = outst_q;
        case ({fire, ack_eff})
            2'b10:   outst_d = outst_q + 4'd1;
            2'b01:   outst_d = outst_q - 4'd1;
            default: outst_d = outst_q;
        endcase
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            in_w_q       <= 16'd0;
            in_h_q       <= 16'd0;
            scale_q      <= 16'd0;
            inv_q        <= 16'd0;
            out_w_q      <= 16'd0;
            out_h_q      <= 16'd0;
            ox_q         <= 16'd0;
            oy_q         <= 16'd0;
            sx_q         <= 24'd0;
            sy_q         <= 24'd0;
            addr_q       <= '0;
            outst_q      <= 4'd0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            in_w_q       <= in_w_d;
            in_h_q       <= in_h_d;
            scale_q      <= scale_d;
            inv_q        <= inv_d;
            out_w_q      <= out_w_d;
            out_h_q      <= out_h_d;
            ox_q         <= ox_d;
            oy_q         <= oy_d;
            sx_q         <= sx_d;
            sy_q         <= sy_d;
            addr_q       <= addr_d;
            outst_q      <= outst_d;
            done_q       <= done_d;
            err_q        <= err_d;
        end
    end

`ifdef DSA_SCAN_PERF_EN
    logic [31:0] perf_q, perf_d;
    logic [31:0] stall_q, stall_d;

    // Run time stops counting the moment completion is flagged; both counters saturate.
    always_comb begin
        perf_d  = perf_q;
        stall_d = stall_q;
        if (accept) begin
            perf_d  = 32'd0;
            stall_d = 32'd0;
        end else begin
            if (busy && !done_q && (perf_q != 32'hFFFF_FFFF)) begin
                perf_d = perf_q + 32'd1;
            end
            if (px_valid && !px_ready && (stall_q != 32'hFFFF_FFFF)) begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge rst_sys) begin
        if (rst_sys) begin
            perf_q  <= 32'd0;
            stall_q <= 32'd0;
        end else begin
            perf_q  <= perf_d;
            stall_q <= stall_d;
        end
    end

    assign perf_cycles  = perf_q;
    assign stall_cycles = stall_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

endmodule

// File: tb/tb_dsa_scan_ctrl.sv
// Directed bench for dsa_scan_ctrl: upscale walk, backpressure, credit limit, size errors, start filtering, reset.
module tb_dsa_scan_ctrl;
    localparam int AW = 12;

    logic          clk_sys = 1'b0;
    logic          rst_sys = 1'b1;
    logic          start_pulse = 1'b0;
    logic [15:0]   cfg_in_w = 16'd0;
    logic [15:0]   cfg_in_h = 16'd0;
    logic [15:0]   cfg_scale_q88 = 16'd0;
    logic [15:0]   cfg_inv_scale_q88 = 16'd0;
    logic          px_valid;
    logic          px_ready = 1'b0;
    logic [15:0]   px_x0;
    logic [15:0]   px_y0;
    logic [7:0]    px_fx;
    logic [7:0]    px_fy;
    logic [AW-1:0] px_out_addr;
    logic          px_ack;
    logic          busy;
    logic          status_done;
    logic          err_size;
    logic [15:0]   out_w;
    logic [15:0]   out_h;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor-owned job log; cleared whenever clr_gen moves.
    int          njobs;
    int          nack;
    bit          vld_seen;
    int          clr_gen = 0;
    int          clr_seen;
    bit          ack_auto = 1'b0;
    bit          ack_manual = 1'b0;
    logic [15:0] j_x0 [0:63];
    logic [15:0] j_y0 [0:63];
    logic [7:0]  j_fx [0:63];
    logic [7:0]  j_fy [0:63];
    logic [11:0] j_addr [0:63];

    always #5 clk_sys = ~clk_sys;

    dsa_scan_ctrl #(.AW(AW), .MAX_OUTSTANDING(4)) dut (
        .clk_sys           (clk_sys),
        .rst_sys           (rst_sys),
        .start_pulse       (start_pulse),
        .cfg_in_w          (cfg_in_w),
        .cfg_in_h          (cfg_in_h),
        .cfg_scale_q88     (cfg_scale_q88),
        .cfg_inv_scale_q88 (cfg_inv_scale_q88),
        .px_valid          (px_valid),
        .px_ready          (px_ready),
        .px_x0             (px_x0),
        .px_y0             (px_y0),
        .px_fx             (px_fx),
        .px_fy             (px_fy),
        .px_out_addr       (px_out_addr),
        .px_ack            (px_ack),
        .busy              (busy),
        .status_done       (status_done),
        .err_size          (err_size),
        .out_w             (out_w),
        .out_h             (out_h)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_cfg(input logic [15:0] w, input logic [15:0] h,
                           input logic [15:0] sc, input logic [15:0] inv);
        cfg_in_w          = w;
        cfg_in_h          = h;
        cfg_scale_q88     = sc;
        cfg_inv_scale_q88 = inv;
    endtask

    // Leaves the caller in cycle N+1 relative to the sampled start edge.
    task automatic start_run();
        clr_gen++;
        tick();
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        for (int i = 0; i < budget && !status_done; i++) tick();
        check_eq(tag, 64'(status_done), 64'd1);
    endtask

    task automatic wait_valid(input int budget, input string tag);
        for (int i = 0; i < budget && !px_valid; i++) tick();
        check_eq(tag, 64'(px_valid), 64'd1);
    endtask

    // Job recorder and ack generator: acks follow each handshake by two cycles when ack_auto is set.
    initial begin
        logic [1:0] pipe;
        logic       hs;
        pipe     = 2'b00;
        px_ack   = 1'b0;
        njobs    = 0;
        nack     = 0;
        vld_seen = 1'b0;
        clr_seen = 0;
        forever begin
            @(negedge clk_sys);
            if (clr_gen != clr_seen) begin
                clr_seen = clr_gen;
                njobs    = 0;
                nack     = 0;
                vld_seen = 1'b0;
            end
            if (px_ack) nack++;
            if (px_valid) vld_seen = 1'b1;
            hs = px_valid && px_ready;
            if (hs) begin
                if (njobs < 64) begin
                    j_x0[njobs]   = px_x0;
                    j_y0[njobs]   = px_y0;
                    j_fx[njobs]   = px_fx;
                    j_fy[njobs]   = px_fy;
                    j_addr[njobs] = px_out_addr;
                end
                njobs++;
            end
            px_ack = (ack_auto && pipe[1]) || ack_manual;
            pipe   = {pipe[0], hs};
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #2;
        check_eq("rst_valid", 64'(px_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_done", 64'(status_done), 64'd0);
        check_eq("rst_err", 64'(err_size), 64'd0);
        check_eq("rst_out_w", 64'(out_w), 64'd0);
        check_eq("rst_out_h", 64'(out_h), 64'd0);
        repeat (3) tick();
        rst_sys = 1'b0;
        repeat (3) tick();
        check_eq("idle_no_valid", 64'(px_valid), 64'd0);

        // Upscale 4x4 by 2 with latency checks
        set_cfg(16'd4, 16'd4, 16'h0200, 16'h0080);
        px_ready = 1'b1;
        ack_auto = 1'b1;
        start_run();
        check_eq("lat_n1_busy", 64'(busy), 64'd1);
        check_eq("lat_n1_valid", 64'(px_valid), 64'd0);
        tick();
        check_eq("lat_n2_out_wh", {32'd0, out_w, out_h}, {32'd0, 16'd8, 16'd8});
        check_eq("lat_n2_valid", 64'(px_valid), 64'd0);
        tick();
        check_eq("lat_n3_valid", 64'(px_valid), 64'd1);
        wait_done(400, "up_done");
        check_eq("up_acks_at_done", 64'(nack), 64'd64);
        check_eq("up_jobs", 64'(njobs), 64'd64);
        check_eq("up_job0", {j_x0[0], j_fx[0], j_addr[0]}, {16'd0, 8'h00, 12'd0});
        check_eq("up_job1", {j_x0[1], j_fx[1], j_addr[1]}, {16'd0, 8'h80, 12'd1});
        check_eq("up_job5", {j_x0[5], j_fx[5]}, {16'd2, 8'h80});
        check_eq("up_job7", {j_x0[7], j_fx[7]}, {16'd3, 8'h00});
        check_eq("up_job8", {j_x0[8], j_fx[8], j_y0[8], j_fy[8], j_addr[8]},
                 {16'd0, 8'h00, 16'd0, 8'h80, 12'd8});
        check_eq("up_job63", {j_x0[63], j_y0[63], j_fy[63], j_addr[63]},
                 {16'd3, 16'd3, 8'h00, 12'd63});
        check_eq("up_busy_end", 64'(busy), 64'd0);
        check_eq("up_err", 64'(err_size), 64'd0);

        // Backpressure: job2 held for 5 cycles, then exactly one advance
        set_cfg(16'd4, 16'd4, 16'h0100, 16'h0140);
        px_ready = 1'b0;
        start_run();
        wait_valid(20, "bp_first_valid");
        px_ready = 1'b1;
        tick();
        tick();
        px_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check_eq("bp_hold", {3'd0, px_valid, px_x0, px_fx, px_y0, px_fy, px_out_addr},
                     {3'd0, 1'b1, 16'd2, 8'h80, 16'd0, 8'h00, 12'd2});
            tick();
        end
        px_ready = 1'b1;
        tick();
        check_eq("bp_advance", {px_valid, px_x0, px_fx, px_out_addr}, {1'b1, 16'd3, 8'h00, 12'd3});
        px_ready = 1'b0;
        tick();
        check_eq("bp_once", {px_valid, px_x0, px_fx, px_out_addr}, {1'b1, 16'd3, 8'h00, 12'd3});
        px_ready = 1'b1;
        wait_done(200, "bp_done");
        check_eq("bp_jobs", 64'(njobs), 64'd16);

        // Outstanding limit
        set_cfg(16'd4, 16'd4, 16'h0100, 16'h0100);
        ack_auto = 1'b0;
        start_run();
        repeat (12) tick();
        check_eq("lim_jobs4", 64'(njobs), 64'd4);
        check_eq("lim_valid_low", 64'(px_valid), 64'd0);
        ack_manual = 1'b1;
        tick();
        ack_manual = 1'b0;
        repeat (8) tick();
        check_eq("lim_jobs5", 64'(njobs), 64'd5);
        check_eq("lim_valid_low2", 64'(px_valid), 64'd0);
        ack_manual = 1'b1;
        wait_done(200, "lim_done");
        ack_manual = 1'b0;
        check_eq("lim_jobs_total", 64'(njobs), 64'd16);

        // Held start and a second edge during ISSUE
        ack_auto = 1'b1;
        tick();
        clr_gen++;
        tick();
        start_pulse = 1'b1;
        repeat (8) tick();
        start_pulse = 1'b0;
        tick();
        start_pulse = 1'b1;
        tick();
        start_pulse = 1'b0;
        wait_done(200, "busy_done");
        check_eq("busy_jobs", 64'(njobs), 64'd16);
        repeat (10) tick();
        check_eq("busy_jobs_after", 64'(njobs), 64'd16);
        check_eq("busy_idle", 64'(busy), 64'd0);

        // Size error: 256x256 output exceeds 4096
        set_cfg(16'd64, 16'd64, 16'h0400, 16'h0040);
        start_run();
        check_eq("err_n1_cleared", {62'd0, status_done, err_size}, 64'd0);
        tick();
        tick();
        check_eq("err_n3_flags", {62'd0, status_done, err_size}, 64'd3);
        check_eq("err_busy", 64'(busy), 64'd0);
        check_eq("err_out_w", 64'(out_w), 64'd256);
        repeat (5) tick();
        check_eq("err_no_valid", 64'(vld_seen), 64'd0);

        // Zero input width
        set_cfg(16'd0, 16'd4, 16'h0100, 16'h0100);
        start_run();
        check_eq("zw_n1_err", 64'(err_size), 64'd0);
        tick();
        tick();
        check_eq("zw_n3_err", {62'd0, status_done, err_size}, 64'd3);

        // Exactly 2**AW pixels is accepted; reset mid-run
        set_cfg(16'd64, 16'd64, 16'h0100, 16'h0100);
        start_run();
        tick();
        tick();
        check_eq("fit_valid", {62'd0, px_valid, err_size}, 64'd2);
        repeat (20) tick();
        #3;
        rst_sys = 1'b1;
        #1;
        check_eq("arst_outs", {29'd0, px_valid, busy, status_done, err_size, out_w, out_h},
                 64'd0);
        tick();
        rst_sys = 1'b0;
        repeat (10) tick();
        check_eq("post_rst_idle", {62'd0, px_valid, busy}, 64'd0);

        // Acks that arrived after reset release must not corrupt the credit count
        set_cfg(16'd4, 16'd4, 16'h0100, 16'h0100);
        start_run();
        wait_done(200, "post_rst_done");
        check_eq("post_rst_jobs", 64'(njobs), 64'd16);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsa_scan_ctrl.md
Name: dsa_scan_ctrl

Overview:
Sequencer for the bilinear scaling datapath. On a start request it latches the JTAG-written configuration and computes the output image size. It then walks every output pixel in raster order, issuing one job per pixel to the interpolation datapath. Each job carries the source integer coordinates, the Q0.8 fractions and the output BRAM address. The block sits between the JTAG register bank and the bilinear core, and drives the status_done bit read back by the host.

Parameters:
AW, 12, output BRAM address width; the image must fit in 2**AW pixels
MAX_OUTSTANDING, 4, maximum jobs issued but not yet acknowledged by the datapath (1..15)

Ports:
clk_sys  in  1  system clock
rst_sys  in  1  asynchronous reset, active-high
start_pulse  in  1  start request from the register bank (may be held several cycles)
cfg_in_w  in  16  input width in pixels
cfg_in_h  in  16  input height in pixels
cfg_scale_q88  in  16  scale factor, Q8.8
cfg_inv_scale_q88  in  16  source step per output pixel, Q8.8 (1/scale, written by host)
px_valid  out  1  job valid
px_ready  in  1  datapath accepts job
px_x0  out  16  source column (integer part)
px_y0  out  16  source row (integer part)
px_fx  out  8  horizontal fraction, Q0.8
px_fy  out  8  vertical fraction, Q0.8
px_out_addr  out  AW  output BRAM write address
px_ack  in  1  one-cycle pulse per completed job
busy  out  1  high from SETUP through DRAIN
status_done  out  1  sticky completion flag
err_size  out  1  sticky: configuration rejected
out_w  out  16  computed output width
out_h  out  16  computed output height

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; all counters 0.
- Start acceptance:
  - Rising edge of start_pulse (registered previous value) is accepted only in IDLE. Edges in any other state are ignored.
  - Acceptance latches all cfg_* inputs and clears status_done and err_size.
- FSM states: IDLE -> SETUP -> CHECK -> ISSUE -> DRAIN -> IDLE.
- SETUP (1 cycle):
  - prod_w = cfg_in_w * cfg_scale_q88 (32b); prod_h likewise.
  - out_w = prod_w >> 8, clamped to [1, 0xFFFF]; out_h likewise.
- CHECK (1 cycle):
  - If in_w == 0, in_h == 0, or out_w*out_h > 2**AW: set err_size=1, status_done=1, return to IDLE; no job is issued.
  - Otherwise clear ox, oy, sx, sy and enter ISSUE.
- Latency: start edge sampled at cycle N gives first px_valid high in cycle N+3.
- ISSUE:
  - Source accumulators sx, sy are Q16.8, 24b.
  - px_x0 = sx[23:8], px_fx = sx[7:0]. If sx[23:8] >= in_w-1, then px_x0 = in_w-1 and px_fx = 0. Y uses the same rule.
  - px_out_addr = oy*out_w + ox, truncated to AW bits.
  - px_valid asserts only while outstanding < MAX_OUTSTANDING.
  - Once asserted, px_valid and all payload stay stable until px_ready is sampled high.
  - On each handshake: ox++, sx += inv_scale.
  - When ox == out_w-1 at handshake: ox=0, sx=0, oy++, sy += inv_scale.
  - After the last pixel (ox=out_w-1, oy=out_h-1) handshake, go to DRAIN.
- Outstanding counter:
  - +1 on handshake, -1 on px_ack; unchanged when both occur in the same cycle.
  - px_ack while the counter is 0 is ignored (no underflow).
- DRAIN: when outstanding == 0, set status_done=1, deassert busy, go to IDLE in the same cycle.
- status_done and err_size hold until the next accepted start or reset.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. In-flight acks after reset release are ignored.

Optional Feature:
DSA_SCAN_PERF_EN
- Defined: adds output perf_cycles (32b).
  - Cleared on accepted start; increments every cycle while busy; frozen when status_done sets.
  - Saturates at 0xFFFFFFFF.
  - Also adds stall_cycles (32b): counts cycles where px_valid=1 and px_ready=0.
- Undefined: both ports and counters are absent.

Test Plan:
- Reset: assert rst_sys mid-cycle -> all outputs 0 asynchronously; px_valid stays 0 after release with no start.
- Upscale, in 4x4, scale 0x0200, inv 0x0080, px_ready=1, px_ack 2 cycles after each handshake:
  - out_w=out_h=8; exactly 64 jobs; status_done=1 after the 64th ack.
  - Job0: x0=0, fx=0x00. Job1: x0=0, fx=0x80.
  - Job7: x0 clamped to 3, fx=0. Last job: px_out_addr=63.
- Backpressure: hold px_ready=0 for 5 cycles with px_valid high -> payload bit-identical across all 5 cycles; ox advances exactly once after ready.
- Outstanding limit: never pulse px_ack -> px_valid drops after 4 handshakes. One px_ack -> exactly one more job issued.
- Size error: in 64x64, scale 0x0400 (out 256x256 = 65536 > 4096) -> err_size=1 and status_done=1 at N+3; px_valid never high.
- Start during busy: second rising start edge mid-ISSUE -> ignored, job count unchanged. start_pulse held 8 cycles -> one run only.
